// File: rtl/sd_pkg.sv
// Shared definitions for the SD sector writer: write FSM encodings, sector geometry,
// and a saturating counter helper.
package sd_pkg;
  localparam int         SECTOR_BYTES = 512;
  localparam logic [8:0] LAST_IDX     = 9'(SECTOR_BYTES - 1);

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_START  = 2'd1,
    W_STREAM = 2'd2,
    W_ERR    = 2'd3
  } wstate_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/sd_sector_pingpong_buf.sv
// Two 512-byte sector banks addressed as {bank,addr}: one write port, one registered read
// port (1-cycle latency, output holds when re_i is low). No backpressure.
module sd_sector_pingpong_buf (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [9:0] waddr_i,
  input  logic [7:0] wdata_i,
  input  logic       re_i,
  input  logic [9:0] raddr_i,
  output logic [7:0] rdata_o
);
  logic [7:0] mem_q [1024];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= 8'h00;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sd_sector_write_scheduler.sv
// Packs a byte stream into ping-pong sectors and issues one sd_write block per full sector;
// in_ready drops while the fill bank is full, padding, flushing or in error.
module sd_sector_write_scheduler
  import sd_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE    = 8'h00,
  parameter logic [31:0] TIMEOUT_CYC = 32'd8000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] base_sector,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        flush,
  output logic        flush_done,
  output logic        wr_start,
  output logic [31:0] wr_sector,
  output logic [7:0]  wr_byte,
  input  logic        wr_byte_ack,
  input  logic        wr_block_done,
  input  logic        wr_busy,
  output logic [31:0] sectors_written,
  output logic        busy,
  output logic        error
);
  wstate_e     state_q, state_d;
  logic        session_q, session_d;
  logic        fill_bank_q, fill_bank_d, drain_bank_q, drain_bank_d;
  logic [8:0]  fill_cnt_q, fill_cnt_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  bank_full_q, bank_full_d;
  logic        pad_q, pad_d, flush_wait_q, flush_wait_d, error_q, error_d;
  logic [31:0] wd_q, wd_d, next_sector_q, next_sector_d;
  logic [31:0] wr_sector_q, wr_sector_d, sectors_written_q, sectors_written_d;

  logic        release_c, bank_free_c, accept_c, start_ok_c, ram_re;
  logic [9:0]  ram_raddr;

  // A bank being released this cycle is immediately fillable again.
  assign release_c   = (state_q == W_STREAM) && wr_block_done;
  assign bank_free_c = !bank_full_q[fill_bank_q] || (release_c && (drain_bank_q == fill_bank_q));
  assign in_ready    = session_q && bank_free_c && !pad_q && !flush_wait_q && !error_q;
  assign accept_c    = in_valid && in_ready;
  assign busy        = (|bank_full_q) || (state_q != W_IDLE) || pad_q;
  assign start_ok_c  = start && (!busy || (state_q == W_ERR));
  assign flush_done  = flush_wait_q && !pad_q && (fill_cnt_q == 9'd0) && (bank_full_q == 2'b00)
                       && (state_q == W_IDLE);

  always_comb begin
    state_d           = state_q;
    session_d         = session_q;
    fill_bank_d       = fill_bank_q;
    drain_bank_d      = drain_bank_q;
    fill_cnt_d        = fill_cnt_q;
    rd_ptr_d          = rd_ptr_q;
    bank_full_d       = bank_full_q;
    pad_d             = pad_q;
    flush_wait_d      = flush_wait_q;
    error_d           = error_q;
    wd_d              = wd_q;
    next_sector_d     = next_sector_q;
    wr_sector_d       = wr_sector_q;
    sectors_written_d = sectors_written_q;
    ram_re            = 1'b0;

    if (release_c) bank_full_d[drain_bank_q] = 1'b0;

    if (flush && !pad_q && !flush_wait_q) flush_wait_d = 1'b1;
    if (flush_wait_q && !pad_q && (fill_cnt_q != 9'd0)) pad_d = 1'b1;
    if (flush_done) flush_wait_d = 1'b0;

    if (accept_c || pad_q) begin
      fill_cnt_d = fill_cnt_q + 9'd1;
      if (fill_cnt_q == LAST_IDX) begin
        bank_full_d[fill_bank_q] = 1'b1;
        fill_bank_d              = !fill_bank_q;
        pad_d                    = 1'b0;
      end
    end

    unique case (state_q)
      W_IDLE: begin
        if (bank_full_q[drain_bank_q] && !wr_busy) begin
          rd_ptr_d    = 9'd0;
          ram_re      = 1'b1;
          wr_sector_d = next_sector_q;
          state_d     = W_START;
        end
      end
      W_START: begin
        wd_d    = 32'd0;
        state_d = W_STREAM;
      end
      W_STREAM: begin
        if (wr_block_done) begin
          drain_bank_d      = !drain_bank_q;
          next_sector_d     = next_sector_q + 32'd1;
          sectors_written_d = sectors_written_q + 32'd1;
          state_d           = W_IDLE;
        end else begin
          if (wr_byte_ack) begin
            ram_re   = 1'b1;
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? rd_ptr_q : rd_ptr_q + 9'd1;
          end
          wd_d = sat_inc32(wd_q);
          if (wd_d >= TIMEOUT_CYC) begin
            state_d = W_ERR;
            error_d = 1'b1;
          end
        end
      end
      W_ERR: ;
      default: state_d = W_IDLE;
    endcase

    if (start_ok_c) begin
      session_d         = 1'b1;
      next_sector_d     = base_sector;
      fill_bank_d       = 1'b0;
      drain_bank_d      = 1'b0;
      fill_cnt_d        = 9'd0;
      bank_full_d       = 2'b00;
      pad_d             = 1'b0;
      flush_wait_d      = 1'b0;
      error_d           = 1'b0;
      sectors_written_d = 32'd0;
      state_d           = W_IDLE;
    end

    ram_raddr = {drain_bank_q, rd_ptr_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= W_IDLE;
      session_q         <= 1'b0;
      fill_bank_q       <= 1'b0;
      drain_bank_q      <= 1'b0;
      fill_cnt_q        <= 9'd0;
      rd_ptr_q          <= 9'd0;
      bank_full_q       <= 2'b00;
      pad_q             <= 1'b0;
      flush_wait_q      <= 1'b0;
      error_q           <= 1'b0;
      wd_q              <= 32'd0;
      next_sector_q     <= 32'd0;
      wr_sector_q       <= 32'd0;
      sectors_written_q <= 32'd0;
    end else begin
      state_q           <= state_d;
      session_q         <= session_d;
      fill_bank_q       <= fill_bank_d;
      drain_bank_q      <= drain_bank_d;
      fill_cnt_q        <= fill_cnt_d;
      rd_ptr_q          <= rd_ptr_d;
      bank_full_q       <= bank_full_d;
      pad_q             <= pad_d;
      flush_wait_q      <= flush_wait_d;
      error_q           <= error_d;
      wd_q              <= wd_d;
      next_sector_q     <= next_sector_d;
      wr_sector_q       <= wr_sector_d;
      sectors_written_q <= sectors_written_d;
    end
  end

  sd_sector_pingpong_buf u_buf (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (accept_c || pad_q),
    .waddr_i ({fill_bank_q, fill_cnt_q}),
    .wdata_i (pad_q ? PAD_BYTE : in_data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (wr_byte)
  );

  assign wr_start        = (state_q == W_START);
  assign wr_sector       = wr_sector_q;
  assign sectors_written = sectors_written_q;
  assign error           = error_q;
endmodule

// File: tb/tb_sd_sector_write_scheduler.sv
// Directed bench: a protocol-level sd_write model consumes each block and checks sector
// numbers and byte order against a queue of accepted bytes (plus flush padding).
module tb_sd_sector_write_scheduler;
  localparam logic [31:0] TMO  = 32'd3000;
  localparam logic [7:0]  PADV = 8'hA5;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, flush, flush_done, wr_start;
  logic [31:0] base_sector, wr_sector, sectors_written;
  logic [7:0]  in_data, wr_byte;
  logic        wr_byte_ack, wr_block_done, wr_busy, busy, error;
  logic        force_busy, model_busy;

  assign wr_busy = force_busy || model_busy;
  always #5 clk = ~clk;

  sd_sector_write_scheduler #(.PAD_BYTE(PADV), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .base_sector(base_sector),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush(flush), .flush_done(flush_done), .wr_start(wr_start), .wr_sector(wr_sector),
    .wr_byte(wr_byte), .wr_byte_ack(wr_byte_ack), .wr_block_done(wr_block_done),
    .wr_busy(wr_busy), .sectors_written(sectors_written), .busy(busy), .error(error)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;
  int model_cnt = 0, n_acc = 0, t_start = 0, t_err = 0, start_pulses = 0, fd_pulses = 0;
  bit hang_mode = 0, at300 = 0, err_chk_en = 1;
  logic [31:0] base_q = 32'd0;
  logic [7:0]  exp_q[$];
  logic [31:0] seen[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: bound expired or data missing", nm);
  endtask

  // Per-cycle comparison against the model's completed-block count and error expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_start) start_pulses++;
      if (flush_done) fd_pulses++;
      chk("sectors_written", sectors_written, 32'(model_cnt));
      if (err_chk_en) chk("error", 32'(error), 32'd0);
    end
  end

  // sd_write model: one ack per cycle, block_done after the 512th byte.
  initial begin : sd_model
    bit abort;
    wr_byte_ack = 0; wr_block_done = 0; model_busy = 0;
    forever begin
      @(negedge clk);
      if (wr_start && !rst) begin
        chk("wr_sector", wr_sector, base_q + 32'(model_cnt));
        seen.push_back(wr_sector);
        t_start = cyc;
        model_busy = 1;
        if (hang_mode) begin
          while (hang_mode && !rst) @(negedge clk);
        end else begin
          abort = 0;
          @(negedge clk);
          for (int i = 0; i < 512 && !abort; i++) begin
            if (rst) abort = 1;
            else begin
              if (exp_q.size() == 0) begin fail_now("data_underflow"); abort = 1; end
              else chk("wr_byte", 32'(wr_byte), 32'(exp_q.pop_front()));
              if (i == 300) at300 = 1;
              wr_byte_ack = 1; @(posedge clk); #1 wr_byte_ack = 0; @(negedge clk);
            end
          end
          if (!abort && !rst) begin
            wr_block_done = 1; @(posedge clk); #1 wr_block_done = 0;
            model_cnt++;
          end
        end
        model_busy = 0;
      end
    end
  end

  task automatic do_start(input logic [31:0] b);
    @(negedge clk); start = 1; base_sector = b;
    @(posedge clk); #1 start = 0;
    base_q = b; model_cnt = 0; n_acc = 0; exp_q.delete(); seen.delete();
  endtask

  task automatic send_bytes(input int n, input int first);
    for (int k = 0; k < n; k++) begin
      int  waitc;
      bit  done;
      waitc = 0; done = 0;
      @(negedge clk); in_valid = 1; in_data = 8'((first + k) % 256);
      while (!done) begin
        #4;
        if (in_ready) begin done = 1; exp_q.push_back(in_data); n_acc++; end
        @(posedge clk);
        if (!done) begin
          waitc++;
          if (waitc > 20000) begin fail_now("in_ready_wait"); in_valid = 0; return; end
          @(negedge clk);
        end
      end
    end
    @(negedge clk); in_valid = 0;
  endtask

  task automatic do_flush();
    int pad_n;
    pad_n = (512 - (n_acc % 512)) % 512;
    for (int i = 0; i < pad_n; i++) exp_q.push_back(PADV);
    @(negedge clk); flush = 1;
    @(posedge clk); #1 flush = 0;
  endtask

  task automatic wait_sectors(input int n, input int budget);
    int c;
    c = 0;
    while (model_cnt < n && c < budget) begin @(negedge clk); c++; end
    if (model_cnt < n) fail_now("sector_wait");
    repeat (3) @(negedge clk);
    chk("busy_after_drain", 32'(busy), 32'd0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_flush_done"}, 32'(flush_done), 32'd0);
    chk({tag, "_wr_start"}, 32'(wr_start), 32'd0);
    chk({tag, "_wr_sector"}, wr_sector, 32'd0);
    chk({tag, "_wr_byte"}, 32'(wr_byte), 32'd0);
    chk({tag, "_sectors_written"}, sectors_written, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin : main
    int c;
    rst = 1; start = 0; base_sector = 0; in_valid = 0; in_data = 0; flush = 0; force_busy = 0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 0;
    @(negedge clk);
    chk("in_ready_prestart", 32'(in_ready), 32'd0);

    // 1) two full sectors at 100, 101
    do_start(32'd100);
    send_bytes(1024, 0);
    wait_sectors(2, 4000);
    chk("t1_count", 32'(seen.size()), 32'd2);
    chk("t1_sec0", seen[0], 32'd100);
    chk("t1_sec1", seen[1], 32'd101);
    chk("t1_written", sectors_written, 32'd2);

    // 2) card busy for 5000 cycles while 1536 bytes are offered
    force_busy = 1;
    do_start(32'd300);
    fork
      send_bytes(1536, 0);
      begin
        repeat (4000) @(negedge clk);
        chk("t2_accepted_while_busy", 32'(n_acc), 32'd1024);
        chk("t2_in_ready_stalled", 32'(in_ready), 32'd0);
        repeat (1000) @(negedge clk);
        force_busy = 0;
      end
    join
    wait_sectors(3, 6000);
    chk("t2_sec0", seen[0], 32'd300);
    chk("t2_sec1", seen[1], 32'd301);
    chk("t2_sec2", seen[2], 32'd302);

    // 3) 700 bytes then flush: second sector padded
    do_start(32'd500);
    send_bytes(700, 7);
    fd_pulses = 0;
    do_flush();
    c = 0;
    while (fd_pulses == 0 && c < 5000) begin @(negedge clk); c++; end
    if (fd_pulses == 0) fail_now("flush_done_wait");
    repeat (20) @(negedge clk);
    chk("t3_flush_done_once", 32'(fd_pulses), 32'd1);
    chk("t3_written", sectors_written, 32'd2);
    chk("t3_sec1", seen[1], 32'd501);
    chk("t3_busy", 32'(busy), 32'd0);

    // 4) sector address wrap
    do_start(32'hFFFF_FFFF);
    send_bytes(1024, 3);
    wait_sectors(2, 4000);
    chk("t4_sec0", seen[0], 32'hFFFF_FFFF);
    chk("t4_sec1", seen[1], 32'h0000_0000);

    // 5) block never completes: watchdog error, then restart
    hang_mode = 1; err_chk_en = 0;
    do_start(32'd7);
    send_bytes(512, 0);
    c = 0;
    while (!error && c < 32'(TMO) + 2000) begin @(negedge clk); c++; end
    t_err = cyc;
    chk("t5_error_set", 32'(error), 32'd1);
    chk("t5_timeout_window", 32'((t_err - t_start) >= int'(TMO) && (t_err - t_start) <= int'(TMO) + 2), 32'd1);
    chk("t5_in_ready_err", 32'(in_ready), 32'd0);
    chk("t5_busy_err", 32'(busy), 32'd1);
    hang_mode = 0;
    repeat (2) @(negedge clk);
    do_start(32'd50);
    @(negedge clk);
    chk("t5_error_cleared", 32'(error), 32'd0);
    err_chk_en = 1;
    send_bytes(512, 9);
    wait_sectors(1, 3000);
    chk("t5_resume_sec", seen[0], 32'd50);

    // 6) reset mid-stream
    at300 = 0;
    do_start(32'd200);
    send_bytes(512, 0);
    c = 0;
    while (!at300 && c < 3000) begin @(negedge clk); c++; end
    if (!at300) fail_now("t6_reach_byte300");
    @(negedge clk); rst = 1; model_cnt = 0;
    @(negedge clk);
    check_reset("t6_rst");
    rst = 0; start_pulses = 0;
    repeat (600) @(negedge clk);
    chk("t6_no_wr_start", 32'(start_pulses), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
